// File: rtl/psram_xfer_ctrl_pkg.sv
// rtl/psram_xfer_ctrl_pkg.sv - shared types and constants for the PSRAM transfer front-end
//
// Purpose: FSM state encoding, request size codes and the size-to-byte-count
// mapping used by psram_xfer_ctrl.
// Ports: none (package).

package psram_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_XFER      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } xfer_state_e;

  localparam logic [1:0] PSRAM_SIZE_1B  = 2'b00;
  localparam logic [1:0] PSRAM_SIZE_2B  = 2'b01;
  localparam logic [1:0] PSRAM_SIZE_4B  = 2'b10;
  localparam logic [1:0] PSRAM_SIZE_ILL = 2'b11;

  // Illegal size maps to 0 bytes; such requests never reach the core.
  function automatic logic [2:0] size_to_nbyte(input logic [1:0] size);
    case (size)
      PSRAM_SIZE_1B: size_to_nbyte = 3'd1;
      PSRAM_SIZE_2B: size_to_nbyte = 3'd2;
      PSRAM_SIZE_4B: size_to_nbyte = 3'd4;
      default:       size_to_nbyte = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/psram_xfer_ctrl.sv
// rtl/psram_xfer_ctrl.sv - single-outstanding request front-end for the PSRAM OPI core
//
// Purpose: accepts one read/write/config request at a time, holds transfer
// parameters stable for the core, streams write bytes out and read bytes in,
// and returns one registered response per request. A watchdog aborts
// transfers that make no progress for TIMEOUT_CYC cycles.
// Ports:
//   clk_i, rst_n_i                   clock, async active-low reset
//   req_*                            request handshake and parameters
//   rsp_valid_o/rsp_rdata_o/rsp_err_o one-cycle response
//   core_*                           latched transfer controls / core completion
//   tx_byte_o/tx_valid_o/tx_ready_i  write byte stream to the core
//   rx_byte_i/rx_valid_i             read byte strobe from the core

module psram_xfer_ctrl
  import psram_xfer_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 24,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_WIDTH    = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_cfg_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  core_en_o,
  output logic                  core_cflg_o,
  output logic                  core_we_o,
  output logic [ADDR_WIDTH-1:0] core_addr_o,
  output logic [2:0]            core_nbyte_o,
  input  logic                  core_done_i,
  output logic [7:0]            tx_byte_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [7:0]            rx_byte_i,
  input  logic                  rx_valid_i
);

  // Last watchdog value before the abort fires on the next idle cycle.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYC - 1);

  xfer_state_e           state_q, state_d;
  logic                  we_q, we_d;
  logic                  cfg_q, cfg_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            nbyte_q, nbyte_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [2:0]            idx_q, idx_d;
  logic [TO_WIDTH-1:0]   wd_q, wd_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic tx_hs;
  logic progress;

  assign req_ready_o  = (state_q == ST_IDLE);
  assign core_en_o    = (state_q == ST_XFER) || (state_q == ST_WAIT_DONE);
  assign core_cflg_o  = cfg_q;
  assign core_we_o    = we_q;
  assign core_addr_o  = addr_q;
  assign core_nbyte_o = nbyte_q;
  assign tx_valid_o   = (state_q == ST_XFER) && we_q && (idx_q < nbyte_q);
  assign tx_byte_o    = wdata_q[{idx_q[1:0], 3'b000} +: 8];
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_err_o    = rsp_err_q;

  assign tx_hs    = tx_valid_o && tx_ready_i;
  assign progress = tx_hs || rx_valid_i;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    cfg_d       = cfg_q;
    addr_d      = addr_q;
    nbyte_d     = nbyte_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          idx_d   = '0;
          wd_d    = '0;
          rdata_d = '0;
          if (req_size_i == PSRAM_SIZE_ILL) begin
            // Rejected without touching the core-facing fields.
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            we_d    = req_we_i;
            cfg_d   = req_cfg_i;
            addr_d  = req_addr_i;
            nbyte_d = size_to_nbyte(req_size_i);
            wdata_d = req_wdata_i;
            state_d = ST_XFER;
          end
        end
      end

      ST_XFER: begin
        if (we_q) begin
          if (tx_hs) idx_d = idx_q + 3'd1;
        end else if (rx_valid_i && (idx_q < nbyte_q)) begin
          rdata_d[{idx_q[1:0], 3'b000} +: 8] = rx_byte_i;
          idx_d = idx_q + 3'd1;
        end
        wd_d = progress ? '0 : wd_q + TO_WIDTH'(1);
        // Completion beats the watchdog when both land on the same cycle.
        if (core_done_i) begin
          state_d = ST_RESP;
        end else if (!progress && (wd_q == TO_LAST)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else if (idx_d == nbyte_q) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        wd_d = rx_valid_i ? '0 : wd_q + TO_WIDTH'(1);
        if (core_done_i) begin
          state_d = ST_RESP;
        end else if (!rx_valid_i && (wd_q == TO_LAST)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rdata_q;
        rsp_err_d   = err_q;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      cfg_q       <= 1'b0;
      addr_q      <= '0;
      nbyte_q     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      cfg_q       <= cfg_d;
      addr_q      <= addr_d;
      nbyte_q     <= nbyte_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_psram_xfer_ctrl.sv
// tb/tb_psram_xfer_ctrl.sv - directed self-checking bench for psram_xfer_ctrl

module tb_psram_xfer_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic        req_cfg_i;
  logic [23:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        core_en_o;
  logic        core_cflg_o;
  logic        core_we_o;
  logic [23:0] core_addr_o;
  logic [2:0]  core_nbyte_o;
  logic        core_done_i;
  logic [7:0]  tx_byte_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_byte_i;
  logic        rx_valid_i;

  int tests = 0;
  int fails = 0;
  int en_cnt;

  psram_xfer_ctrl #(
    .ADDR_WIDTH (24),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_cfg_i   (req_cfg_i),
    .req_addr_i  (req_addr_i),
    .req_size_i  (req_size_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .core_en_o   (core_en_o),
    .core_cflg_o (core_cflg_o),
    .core_we_o   (core_we_o),
    .core_addr_o (core_addr_o),
    .core_nbyte_o(core_nbyte_o),
    .core_done_i (core_done_i),
    .tx_byte_o   (tx_byte_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .rx_byte_i   (rx_byte_i),
    .rx_valid_i  (rx_valid_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic issue(input logic we, input logic cfg, input logic [23:0] addr,
                       input logic [1:0] size, input logic [31:0] wdata);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_cfg_i   = cfg;
    req_addr_i  = addr;
    req_size_i  = size;
    req_wdata_i = wdata;
  endtask

  initial begin
    rst_n_i     = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_cfg_i   = 1'b0;
    req_addr_i  = '0;
    req_size_i  = '0;
    req_wdata_i = '0;
    core_done_i = 1'b0;
    tx_ready_i  = 1'b0;
    rx_byte_i   = '0;
    rx_valid_i  = 1'b0;
    step(); step();

    // Reset state
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_rsp_err",   32'(rsp_err_o), 32'd0);
    chk("rst_core_en",   32'(core_en_o), 32'd0);
    chk("rst_tx_valid",  32'(tx_valid_o), 32'd0);
    chk("rst_core_addr", 32'(core_addr_o), 32'd0);
    chk("rst_nbyte",     32'(core_nbyte_o), 32'd0);
    rst_n_i = 1'b1;
    step();

    // Write 4B, tx_ready always high
    issue(1'b1, 1'b0, 24'h000100, 2'b10, 32'hA1B2C3D4);
    tx_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    chk("wr_core_en",   32'(core_en_o), 32'd1);
    chk("wr_req_ready", 32'(req_ready_o), 32'd0);
    chk("wr_addr",      32'(core_addr_o), 32'h100);
    chk("wr_nbyte",     32'(core_nbyte_o), 32'd4);
    chk("wr_we",        32'(core_we_o), 32'd1);
    chk("wr_tx_valid0", 32'(tx_valid_o), 32'd1);
    chk("wr_byte0",     32'(tx_byte_o), 32'hD4);
    step();
    chk("wr_byte1",     32'(tx_byte_o), 32'hC3);
    step();
    chk("wr_byte2",     32'(tx_byte_o), 32'hB2);
    step();
    chk("wr_byte3",     32'(tx_byte_o), 32'hA1);
    chk("wr_tx_valid3", 32'(tx_valid_o), 32'd1);
    step();
    chk("wr_wait_txv",  32'(tx_valid_o), 32'd0);
    chk("wr_wait_en",   32'(core_en_o), 32'd1);
    core_done_i = 1'b1;
    step();
    core_done_i = 1'b0;
    tx_ready_i  = 1'b0;
    chk("wr_resp_en",   32'(core_en_o), 32'd0);
    chk("wr_resp_pre",  32'(rsp_valid_o), 32'd0);
    step();
    chk("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("wr_rsp_err",   32'(rsp_err_o), 32'd0);
    chk("wr_rsp_rdata", rsp_rdata_o, 32'd0);
    step();
    chk("wr_rsp_once",  32'(rsp_valid_o), 32'd0);

    // Read 2B with an extra strobe after the last byte
    issue(1'b0, 1'b0, 24'h000020, 2'b01, 32'h0);
    step();
    req_valid_i = 1'b0;
    chk("rd_nbyte",    32'(core_nbyte_o), 32'd2);
    chk("rd_tx_valid", 32'(tx_valid_o), 32'd0);
    rx_valid_i = 1'b1;
    rx_byte_i  = 8'h5A;
    step();
    rx_byte_i  = 8'h3C;
    step();
    rx_byte_i  = 8'hFF;
    step();
    rx_valid_i  = 1'b0;
    core_done_i = 1'b1;
    step();
    core_done_i = 1'b0;
    step();
    chk("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata_o, 32'h00003C5A);
    chk("rd_rsp_err",   32'(rsp_err_o), 32'd0);
    step();

    // Illegal size
    issue(1'b1, 1'b0, 24'h000300, 2'b11, 32'h12345678);
    step();
    req_valid_i = 1'b0;
    chk("ill_core_en1",  32'(core_en_o), 32'd0);
    chk("ill_rsp_early", 32'(rsp_valid_o), 32'd0);
    step();
    chk("ill_core_en2",  32'(core_en_o), 32'd0);
    chk("ill_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("ill_rsp_err",   32'(rsp_err_o), 32'd1);
    chk("ill_rsp_rdata", rsp_rdata_o, 32'd0);
    step();

    // Read 4B, core silent -> timeout after 16 idle cycles
    issue(1'b0, 1'b0, 24'h000040, 2'b10, 32'h0);
    en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      req_valid_i = 1'b0;
      if (core_en_o) en_cnt++;
    end
    chk("to_en_cycles", 32'(en_cnt), 32'd16);
    step();
    chk("to_en_drop",   32'(core_en_o), 32'd0);
    step();
    chk("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("to_rsp_err",   32'(rsp_err_o), 32'd1);
    chk("to_rsp_rdata", rsp_rdata_o, 32'd0);
    step();

    // Read 4B, one byte then silence; done lands on the timeout cycle
    issue(1'b0, 1'b0, 24'h000044, 2'b10, 32'h0);
    step();
    req_valid_i = 1'b0;
    rx_valid_i  = 1'b1;
    rx_byte_i   = 8'h77;
    step();
    rx_valid_i  = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("tod_en_last", 32'(core_en_o), 32'd1);
    core_done_i = 1'b1;
    step();
    core_done_i = 1'b0;
    chk("tod_en_drop",   32'(core_en_o), 32'd0);
    step();
    chk("tod_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("tod_rsp_err",   32'(rsp_err_o), 32'd0);
    chk("tod_rsp_rdata", rsp_rdata_o, 32'h00000077);
    step();

    // Config write finished early by the core while still in XFER
    issue(1'b1, 1'b1, 24'h000004, 2'b00, 32'h000000EE);
    tx_ready_i = 1'b0;
    step();
    req_valid_i = 1'b0;
    chk("cfg_cflg0",    32'(core_cflg_o), 32'd1);
    chk("cfg_tx_valid", 32'(tx_valid_o), 32'd1);
    chk("cfg_tx_byte",  32'(tx_byte_o), 32'hEE);
    chk("cfg_nbyte",    32'(core_nbyte_o), 32'd1);
    core_done_i = 1'b1;
    step();
    core_done_i = 1'b0;
    chk("cfg_cflg1",    32'(core_cflg_o), 32'd1);
    chk("cfg_en_drop",  32'(core_en_o), 32'd0);
    step();
    chk("cfg_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("cfg_rsp_err",   32'(rsp_err_o), 32'd0);
    chk("cfg_cflg2",     32'(core_cflg_o), 32'd1);
    step();

    // Reset in the middle of a write
    issue(1'b1, 1'b0, 24'h000500, 2'b10, 32'h11223344);
    tx_ready_i = 1'b0;
    step();
    req_valid_i = 1'b0;
    chk("mrst_en_pre", 32'(core_en_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    chk("mrst_en",     32'(core_en_o), 32'd0);
    chk("mrst_txv",    32'(tx_valid_o), 32'd0);
    chk("mrst_ready",  32'(req_ready_o), 32'd1);
    step();
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    chk("mrst_addr", 32'(core_addr_o), 32'd0);

    // Normal 1B read after the reset
    issue(1'b0, 1'b0, 24'h000600, 2'b00, 32'h0);
    step();
    req_valid_i = 1'b0;
    chk("post_en", 32'(core_en_o), 32'd1);
    rx_valid_i = 1'b1;
    rx_byte_i  = 8'h9C;
    step();
    rx_valid_i  = 1'b0;
    core_done_i = 1'b1;
    step();
    core_done_i = 1'b0;
    step();
    chk("post_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("post_rsp_rdata", rsp_rdata_o, 32'h0000009C);
    chk("post_rsp_err",   32'(rsp_err_o), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
